// File: rtl/pe_rs_param_pkg.sv
// pe_rs_param_pkg: shared FSM state type, accumulate-mode constants and the wrap/saturate adder
package pe_rs_param_pkg;
    typedef enum logic [1:0] {IDLE, COMPUTE, FLUSH, DRAIN} state_t;
    localparam int SAT_WRAP  = 0;
    localparam int SAT_CLAMP = 1;
    // a and b hold w-bit two's-complement values zero-extended to 32 bits (w <= 32)
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w, input logic sat);
        logic [4:0] m;
        logic [31:0] mask;
        logic [31:0] s;
        m = 5'(w - 1);
        mask = 32'hFFFF_FFFF >> (32 - w);
        s = (a + b) & mask;
        return (sat && a[m] == b[m] && s[m] != a[m]) ? (a[m] ? mask ^ (mask >> 1) : mask >> 1) : s;
    endfunction
endpackage

// File: rtl/pe_mac_pipe.sv
// pe_mac_pipe: two-stage multiply-accumulate; stage 1 registers the product, stage 2 the new psum,
// with the in-flight psum forwarded when consecutive MACs hit the same entry
module pe_mac_pipe
    import pe_rs_param_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IDX_W = 5,
    parameter int SAT = SAT_WRAP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [IDX_W-1:0]  idx,
    output logic [IDX_W-1:0]  rd_idx,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_valid,
    output logic [IDX_W-1:0]  wr_idx,
    output logic [DATA_W-1:0] wr_data
);
    logic [2*DATA_W-1:0] full;
    logic [DATA_W:0] hi;
    logic ovf;
    logic [DATA_W-1:0] prod, p1, base, sum;
    logic [IDX_W-1:0] i1;
    logic v1;
    assign full = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
    assign hi = full[2*DATA_W-1:DATA_W-1];
    // in clamp mode an unrepresentable product saturates too, so large products never flip sign
    assign ovf = SAT == SAT_CLAMP && !(&hi || ~|hi);
    assign prod = ovf ? (full[2*DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}}) : full[DATA_W-1:0];
    assign rd_idx = i1;
    assign base = (wr_valid && wr_idx == i1) ? wr_data : rd_data;
    assign sum = DATA_W'(sat_add(32'(base), 32'(p1), DATA_W, SAT == SAT_CLAMP));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            p1 <= '0;
            i1 <= '0;
            wr_valid <= 1'b0;
            wr_idx <= '0;
            wr_data <= '0;
        end else begin
            v1 <= in_valid;
            p1 <= prod;
            i1 <= idx;
            wr_valid <= v1;
            wr_idx <= i1;
            wr_data <= sum;
        end
    end
endmodule

// File: rtl/pe_rs_param.sv
// pe_rs_param: row-stationary PE; loads ifmap/filter scratchpads, runs S*Q*P MACs into P psums,
// then drains psum+ipsum upstream with a valid/ready handshake
module pe_rs_param
    import pe_rs_param_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IF_DEPTH = 12,
    parameter int FILT_DEPTH = 224,
    parameter int PSUM_DEPTH = 24,
    parameter int SAT = SAT_WRAP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        cfg_S,
    input  logic [4:0]        cfg_P,
    input  logic [2:0]        cfg_Q,
    input  logic              if_valid,
    input  logic [DATA_W-1:0] if_data,
    input  logic              filt_valid,
    input  logic [DATA_W-1:0] filt_data,
    output logic              ld_ready,
    input  logic              start,
    input  logic [DATA_W-1:0] ipsum,
    output logic              opsum_valid,
    output logic [DATA_W-1:0] opsum,
    input  logic              opsum_ready,
    output logic              busy,
    output logic              complete,
    output logic              cfg_err
);
    localparam int IW = IF_DEPTH > 1 ? $clog2(IF_DEPTH) : 1;
    localparam int FW = FILT_DEPTH > 1 ? $clog2(FILT_DEPTH) : 1;
    localparam int PW = PSUM_DEPTH > 1 ? $clog2(PSUM_DEPTH) : 1;
    state_t state;
    logic fl;
    logic [IW-1:0] if_wptr, iidx;
    logic [FW-1:0] f_wptr, cnt, n_last;
    logic [PW-1:0] p, k, p_last, rd_idx, wr_idx;
    logic [DATA_W-1:0] ifmap_spad [IF_DEPTH];
    logic [DATA_W-1:0] filt_spad [FILT_DEPTH];
    logic [DATA_W-1:0] psum_spad [PSUM_DEPTH];
    logic [DATA_W-1:0] wr_data;
    logic [6:0] sq;
    logic [11:0] sqp;
    logic cfg_bad, accept, wr_valid;
    assign sq = 7'(cfg_S) * 7'(cfg_Q);
    assign sqp = 12'(sq) * 12'(cfg_P);
    assign cfg_bad = cfg_S == 4'd0 || cfg_Q == 3'd0 || cfg_P == 5'd0 || 32'(sq) > IF_DEPTH
                     || 32'(sqp) > FILT_DEPTH || 32'(cfg_P) > PSUM_DEPTH;
    assign accept = state == IDLE && start && !cfg_bad;
    assign ld_ready = state == IDLE;
    assign busy = state != IDLE;
    assign opsum_valid = state == DRAIN;
    assign opsum = opsum_valid ? DATA_W'(sat_add(32'(psum_spad[k]), 32'(ipsum), DATA_W, SAT == SAT_CLAMP)) : '0;
    pe_mac_pipe #(.DATA_W(DATA_W), .IDX_W(PW), .SAT(SAT)) u_mac (
        .clk(clk),
        .rst(rst),
        .in_valid(state == COMPUTE),
        .a(ifmap_spad[iidx]),
        .b(filt_spad[cnt]),
        .idx(p),
        .rd_idx(rd_idx),
        .rd_data(psum_spad[rd_idx]),
        .wr_valid(wr_valid),
        .wr_idx(wr_idx),
        .wr_data(wr_data)
    );
    always_ff @(posedge clk) begin
        if (state == IDLE && if_valid) ifmap_spad[if_wptr] <= if_data;
        if (state == IDLE && filt_valid) filt_spad[f_wptr] <= filt_data;
        if (accept) for (int i = 0; i < PSUM_DEPTH; i++) psum_spad[i] <= '0;
        else if (wr_valid) psum_spad[wr_idx] <= wr_data;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            fl <= 1'b0;
            if_wptr <= '0;
            f_wptr <= '0;
            cnt <= '0;
            iidx <= '0;
            p <= '0;
            k <= '0;
            n_last <= '0;
            p_last <= '0;
            complete <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            complete <= 1'b0;
            case (state)
                IDLE: begin
                    if_wptr <= accept ? '0 : if_wptr + IW'(if_valid && 32'(if_wptr) != IF_DEPTH - 1);
                    f_wptr <= accept ? '0 : f_wptr + FW'(filt_valid && 32'(f_wptr) != FILT_DEPTH - 1);
                    if (start && cfg_bad) cfg_err <= 1'b1;
                    if (accept) begin
                        cnt <= '0;
                        iidx <= '0;
                        p <= '0;
                        n_last <= FW'(sqp - 12'd1);
                        p_last <= PW'(cfg_P - 5'd1);
                        state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    // cnt is the filter address; iidx (= s*Q+q) advances each time p wraps
                    cnt <= cnt + FW'(1);
                    p <= p == p_last ? '0 : p + PW'(1);
                    iidx <= iidx + IW'(p == p_last);
                    fl <= 1'b0;
                    if (cnt == n_last) state <= FLUSH;
                end
                FLUSH: begin
                    fl <= 1'b1;
                    if (fl) begin
                        state <= DRAIN;
                        k <= '0;
                    end
                end
                DRAIN: begin
                    if (opsum_ready) begin
                        k <= k + PW'(1);
                        if (k == p_last) begin
                            state <= IDLE;
                            complete <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
